// File: rtl/main_store_param_if.sv
// main_store_param_if: request/response bundle for the parametrised main store.
//   master: drives read, write, address, data_i and clear. Receives data_o, valid, err and busy.
//   slave : the store itself, with the directions reversed.
// clk and rst are plain ports on the store and are not part of this bundle.
interface main_store_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_i;
    logic              clear;
    logic [DATA_W-1:0] data_o;
    logic              valid;
    logic              err;
    logic              busy;

    modport master (
        output read, write, address, data_i, clear,
        input  data_o, valid, err, busy
    );

    modport slave (
        input  read, write, address, data_i, clear,
        output data_o, valid, err, busy
    );
endinterface

// File: rtl/main_store_param.sv
// main_store_param: DATA_W x DEPTH word store.
//   - The store has a synchronous write.
//   - Reads are registered and take one cycle. The valid strobe marks each read result.
//   - The err strobe flags an out-of-range read.
//   - A clear sequencer zeroes one word per cycle.
// Ports:
//   clk : the single clock.
//   rst : asynchronous, active-high reset. It zeroes the array and all outputs.
//   bus : main_store_param_if.slave.
//     - Inputs: read, write, address, data_i, clear.
//     - Outputs: data_o, valid, err, busy.
// Build option: define MAIN_STORE_BYPASS_EN so that a same-cycle read and write
// forwards data_i to the read. Without it, the read returns the old word.
module main_store_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    main_store_param_if.slave    bus
);
    // One extra bit so DEPTH = 2**ADDR_W is representable without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [DATA_W-1:0]  data_o_q, data_o_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               addr_ok;

    // Unsigned compare of the zero-extended address against the depth.
    assign addr_ok = ({1'b0, bus.address} < DEPTH_C);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        data_o_d = data_o_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    // clear wins. A read or write in this same cycle is dropped.
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (bus.read) begin
                        valid_d = 1'b1;
                        if (addr_ok) begin
`ifdef MAIN_STORE_BYPASS_EN
                            // Read and write share one address, so write=1 means a collision.
                            data_o_d = bus.write ? bus.data_i : mem_q[bus.address];
`else
                            data_o_d = mem_q[bus.address];
`endif
                        end else begin
                            data_o_d = '0;
                            err_d    = 1'b1;
                        end
                    end
                    if (bus.write && addr_ok) begin
                        mem_d[bus.address] = bus.data_i;
                    end
                end
            end

            CLEAR: begin
                mem_d[cnt_q[ADDR_W-1:0]] = '0;
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_o_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_o_q <= data_o_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.data_o = data_o_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q == CLEAR);
endmodule

// File: tb/tb_main_store_param.sv
// tb_main_store_param: drives two stores from the same stimulus.
//   - u32 has DEPTH=32. u24 has DEPTH=24.
//   - A behavioural model checks both stores every cycle.
//   - Hand-computed literal checks pin down key points.
module tb_main_store_param;
`ifdef MAIN_STORE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0, write = 1'b0, clear = 1'b0;
    logic [4:0] address = '0;
    logic [7:0] data_i = '0;
    bit         chk_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    main_store_param_if #(.DATA_W(8), .ADDR_W(5)) if32 ();
    main_store_param_if #(.DATA_W(8), .ADDR_W(5)) if24 ();

    assign if32.read = read;    assign if24.read = read;
    assign if32.write = write;  assign if24.write = write;
    assign if32.address = address; assign if24.address = address;
    assign if32.data_i = data_i;   assign if24.data_i = data_i;
    assign if32.clear = clear;  assign if24.clear = clear;

    main_store_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) u32 (
        .clk(clk), .rst(rst), .bus(if32.slave));
    main_store_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(24)) u24 (
        .clk(clk), .rst(rst), .bus(if24.slave));

    // ---------------- behavioural model ----------------
    // A clear zeroes the whole model array at once and then counts busy cycles.
    // Nothing can observe the array while busy, so the word-by-word order does not matter here.
    bit [7:0] mem_m [2][32];
    int       bcnt [2] = '{0, 0};
    bit [7:0] e_data [2] = '{8'h00, 8'h00};
    bit       e_valid [2] = '{1'b0, 1'b0};
    bit       e_err [2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        int dp;
        for (int k = 0; k < 2; k++) begin
            dp = (k == 0) ? 32 : 24;
            if (rst) begin
                for (int j = 0; j < 32; j++) mem_m[k][j] = 8'h00;
                bcnt[k] = 0; e_data[k] = 8'h00; e_valid[k] = 1'b0; e_err[k] = 1'b0;
            end else if (bcnt[k] > 0) begin
                bcnt[k]--; e_valid[k] = 1'b0; e_err[k] = 1'b0;
            end else if (clear) begin
                for (int j = 0; j < 32; j++) mem_m[k][j] = 8'h00;
                bcnt[k] = dp; e_valid[k] = 1'b0; e_err[k] = 1'b0;
            end else begin
                if (read) begin
                    e_valid[k] = 1'b1;
                    if (int'(address) < dp) begin
                        e_err[k]  = 1'b0;
                        e_data[k] = (write && BYP) ? data_i : mem_m[k][address];
                    end else begin
                        e_err[k]  = 1'b1;
                        e_data[k] = 8'h00;
                    end
                end else begin
                    e_valid[k] = 1'b0; e_err[k] = 1'b0;
                end
                if (write && int'(address) < dp) mem_m[k][address] = data_i;
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        logic [7:0] a_d; logic a_v, a_e, a_b;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin a_d = if32.data_o; a_v = if32.valid; a_e = if32.err; a_b = if32.busy; end
                else        begin a_d = if24.data_o; a_v = if24.valid; a_e = if24.err; a_b = if24.busy; end
                total++;
                if (a_d !== e_data[k] || a_v !== e_valid[k] || a_e !== e_err[k] || a_b !== (bcnt[k] > 0)) begin
                    bad++;
                    $display("FAIL cycle_cmp u%0d t=%0t: got data_o=%h valid=%b err=%b busy=%b, want %h %b %b %b",
                             (k == 0) ? 32 : 24, $time, a_d, a_v, a_e, a_b,
                             e_data[k], e_valid[k], e_err[k], (bcnt[k] > 0));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Present one request, wait for the edge that samples it, then settle past the next negedge.
    task automatic op(input bit r, input bit w, input int a, input int d, input bit c);
        read = r; write = w; address = 5'(a); data_i = 8'(d); clear = c;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;

        // Reset asserted mid-cycle while a read result is being held.
        op(1'b0, 1'b1, 2, 8'h3C, 1'b0);
        read = 1'b1; write = 1'b0; address = 5'd2;
        @(posedge clk); #2;
        lit("pre_rst_data", 32'(if32.data_o), 32'h3C);
        rst = 1'b1; #1;
        lit("rst_data_o", 32'(if32.data_o), 32'h00);
        lit("rst_valid",  32'(if32.valid), 32'h0);
        lit("rst_err",    32'(if32.err), 32'h0);
        lit("rst_busy",   32'(if32.busy), 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        op(1'b1, 1'b0, 0, 0, 1'b0);
        lit("post_rst_rd0", {23'd0, if32.valid, if32.data_o}, {23'd0, 1'b1, 8'h00});
        op(1'b1, 1'b0, 31, 0, 1'b0);
        lit("post_rst_rd31", {23'd0, if32.valid, if32.data_o}, {23'd0, 1'b1, 8'h00});
        idle();
        lit("valid_drops", 32'(if32.valid), 32'h0);

        // Basic write then read.
        op(1'b0, 1'b1, 3, 8'hA5, 1'b0);
        op(1'b1, 1'b0, 3, 0, 1'b0);
        lit("rd3", {23'd0, if32.valid, if32.data_o}, {23'd0, 1'b1, 8'hA5});
        op(1'b1, 1'b0, 4, 0, 1'b0);
        lit("rd4", 32'(if32.data_o), 32'h00);
        idle();
        lit("data_hold", 32'(if32.data_o), 32'h00);

        // Same-address collision.
        op(1'b0, 1'b1, 7, 8'h11, 1'b0);
        op(1'b1, 1'b1, 7, 8'h22, 1'b0);
        lit("collide7", 32'(if32.data_o), BYP ? 32'h22 : 32'h11);
        op(1'b1, 1'b0, 7, 0, 1'b0);
        lit("after_collide7", 32'(if32.data_o), 32'h22);

        // Fill with 0xFF, clear, then poke the store while it is busy.
        for (int i = 0; i < 32; i++) op(1'b0, 1'b1, i, 8'hFF, 1'b0);
        op(1'b1, 1'b0, 5, 0, 1'b0);
        lit("fill_rd5", 32'(if32.data_o), 32'hFF);
        op(1'b1, 1'b1, 9, 8'h33, 1'b1);
        busy_seen = int'(if32.busy);
        for (int i = 0; i < 40; i++) begin
            if (i < 32) op(1'($urandom), 1'($urandom), $urandom_range(0, 31), $urandom, 1'($urandom));
            else        idle();
            busy_seen += int'(if32.busy);
        end
        lit("busy_cycles", 32'(busy_seen), 32'd32);
        for (int i = 0; i < 32; i++) op(1'b1, 1'b0, i, 0, 1'b0);
        lit("clr_rd31", {23'd0, if32.valid, if32.data_o}, {23'd0, 1'b1, 8'h00});

        // Out-of-range access on the 24-word store.
        for (int i = 0; i < 24; i++) op(1'b0, 1'b1, i, i + 8'h40, 1'b0);
        op(1'b0, 1'b1, 30, 8'h5A, 1'b0);
        op(1'b1, 1'b0, 30, 0, 1'b0);
        lit("oor24", {22'd0, if24.valid, if24.err, if24.data_o}, {22'd0, 1'b1, 1'b1, 8'h00});
        lit("inr32", {22'd0, if32.valid, if32.err, if32.data_o}, {22'd0, 1'b1, 1'b0, 8'h5A});
        for (int i = 0; i < 24; i++) op(1'b1, 1'b0, i, 0, 1'b0);
        lit("rd23_24", 32'(if24.data_o), 32'h57);

        // Reset five cycles into a clear.
        op(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (4) idle();
        @(posedge clk); #2;
        lit("busy_mid_clear", 32'(if32.busy), 32'h1);
        rst = 1'b1; #1;
        lit("busy_abort", 32'(if32.busy), 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        op(1'b0, 1'b1, 20, 8'h77, 1'b0);
        op(1'b1, 1'b0, 20, 0, 1'b0);
        lit("rd20_32", {23'd0, if32.valid, if32.data_o}, {23'd0, 1'b1, 8'h77});
        lit("rd20_24", {23'd0, if24.valid, if24.data_o}, {23'd0, 1'b1, 8'h77});

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 800; i++) begin
            op(1'($urandom), 1'($urandom), $urandom_range(0, 31), $urandom,
               ($urandom_range(0, 63) == 0));
        end
        repeat (40) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/main_store_param.md
# main_store_param

Parametrised successor to the core's 32x8 main store: a DATA_W x DEPTH word memory with a synchronous write, a registered one-cycle read with a valid strobe, an out-of-range error flag, and a hardware clear sequencer that zeroes the array one word per cycle. It sits between the processor's control unit and its data path. It replaces the fixed-size store, with the same read/write/address/data port set plus handshake outputs.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 5, address width in bits
- DEPTH, 32, number of implemented words; must satisfy 1 <= DEPTH <= 2^ADDR_W
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- read  input  1  read request, sampled at the clk edge
- write  input  1  write request, sampled at the clk edge
- address  input  ADDR_W  word address for read and write
- data_i  input  DATA_W  write data
- clear  input  1  request to zero the whole array
- data_o  output  DATA_W  registered read data; holds its value between reads
- valid  output  1  one-cycle strobe marking data_o as the result of an accepted read
- err  output  1  one-cycle strobe, coincident with valid, for an out-of-range read
- busy  output  1  high while the clear sequence runs

## Operation
- rst is asynchronous and active-high. While it is asserted:
  - every word is forced to 0
  - data_o=0, valid=0, err=0, busy=0
  - state=IDLE, clear counter=0
- State machine with two states, IDLE and CLEAR.
- In IDLE, priority is clear > (read, write).
  - If clear=1: move to CLEAR. Any read or write in the same cycle is ignored (no write, no valid).
  - If clear=0, write=1 and address < DEPTH: mem[address] <= data_i.
  - If clear=0, write=1 and address >= DEPTH: the write is dropped silently.
  - If clear=0, read=1 and address < DEPTH: next cycle data_o = mem[address], valid=1, err=0.
  - If clear=0, read=1 and address >= DEPTH: next cycle data_o = 0, valid=1, err=1.
  - If read=0: next cycle valid=0, err=0 and data_o is unchanged.
- read and write in the same cycle:
  - Different addresses: both operations are performed.
  - Same address: the write is performed; read data follows the Configuration rules.
- In CLEAR:
  - busy=1; the counter walks 0..DEPTH-1, writing 0 to one word per cycle.
  - read, write and clear are ignored; valid and err stay 0.
  - After writing word DEPTH-1, return to IDLE with busy=0 and the counter reset to 0.
- Address comparison is unsigned. The counter is ADDR_W+1 bits wide so that DEPTH = 2^ADDR_W does not wrap early.
- rst asserted mid-clear aborts the sequence. The array is fully zeroed by reset regardless.

## Timing
- Read latency is 1 cycle. A request sampled at edge N gives data_o and valid from edge N until edge N+1.
- Back-to-back reads on consecutive cycles give valid high continuously, with data updating every cycle.
- A write sampled at edge N is visible to a read sampled at edge N+1 or later.
- Clear sequencing:
  - clear is sampled at edge N; busy rises after edge N.
  - Edge N+k writes word k-1, for k = 1..DEPTH.
  - busy falls after edge N+DEPTH, so busy is high for exactly DEPTH cycles.
  - The first request accepted after the clear is sampled at edge N+DEPTH+1.
- valid and err are never high while busy=1, and never high in the cycle after a request arrives with busy=1.

## Configuration
- MAIN_STORE_BYPASS_EN governs a read and write to the same in-range address in the same cycle.
- Defined: the read returns data_i (write-first forwarding).
- Undefined: the read returns the word's previous contents (read-first).
- All other behaviour is identical with and without the macro.

## Test plan
- Reset and defaults:
  - Stimulus: assert rst mid-cycle, then release it and read addresses 0 and 31.
  - Response: data_o=0, valid=0, err=0 and busy=0 immediately on rst; after release both reads return 0x00 with valid=1.
- Basic write then read:
  - Stimulus: write 0xA5 to address 3, then read address 3 on the next cycle.
  - Response: data_o=0xA5 and valid=1 one cycle after the read. A read of address 4 returns 0x00.
- Same-address collision:
  - Stimulus: preload 0x11 at address 7, then apply read=1, write=1, data_i=0x22 to address 7 in one cycle.
  - Response: data_o=0x22 with MAIN_STORE_BYPASS_EN, 0x11 without it. A later read of address 7 returns 0x22 in both builds.
- Clear sequence:
  - Stimulus: with DEPTH=32, fill every word with 0xFF, pulse clear, and issue reads and writes during busy.
  - Response: busy is high for exactly 32 cycles; the in-busy reads produce no valid and the in-busy writes have no effect; all 32 words read 0x00 afterwards.
- Out of range:
  - Stimulus: with DEPTH=24, write 0x5A to address 30, then read address 30.
  - Response: valid=1, err=1 and data_o=0x00; words 0..23 are unchanged.
- Reset mid-clear:
  - Stimulus: assert rst 5 cycles into a clear.
  - Response: busy=0 at once and state is IDLE; after release a write then read at address 20 returns the written value.
